burst_rr_arbiter: RTL and testbench

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/burst_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_burst_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg
//   Shared types and default sizing for the burst round-robin arbiter.
//   arb_state_e     : arbiter FSM state (IDLE, GRANT, GAP)
//   ARB_N_DEF       : default number of requesters
//   ARB_CNT_W_DEF   : default quantum / beat counter width
//   ARB_TIMEOUT_DEF : default idle-beat limit (used only with ARB_TIMEOUT_EN)
package arb_pkg;

   localparam int unsigned ARB_N_DEF       = 4;
   localparam int unsigned ARB_CNT_W_DEF   = 4;
   localparam int unsigned ARB_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotating-priority picker. Searches req starting at ptr
//   and moving upward, wrapping modulo N; the first set bit wins.
//   req   [N-1:0]    in  : request vector
//   ptr   [ID_W-1:0] in  : index with highest priority this cycle
//   win   [N-1:0]    out : one-hot winner (all zero when nothing requests)
//   valid            out : at least one request present
module rr_pick
   import arb_pkg::*;
#(
   parameter  int unsigned N    = ARB_N_DEF,
   localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    win,
   output logic            valid
);

   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      valid = 1'b0;
      for (int off = 0; off < int'(N); off++) begin
         idx = (int'(ptr) + off) % int'(N);
         if (!valid && req[idx]) begin
            win[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter
//   Round-robin arbiter granting bursts of up to a per-requester quantum of
//   beats, with a one-cycle gap between grants.
//   clk                      in  : clock, rising edge
//   rst_n                    in  : asynchronous active-low reset
//   REQ    [N-1:0]           in  : request levels
//   BEAT                     in  : owner completed one transfer this cycle
//   WEIGHT [N*CNT_W-1:0]     in  : quantum of requester i at [i*CNT_W +: CNT_W]
//   GNT    [N-1:0]           out : registered one-hot grant
//   GNT_ID [ID_W-1:0]        out : owner index, 0 when not busy
//   BUSY                     out : |GNT
//   TIMEOUT_ERR              out : pulse in the GAP after a timeout revoke
//   Build option: ARB_TIMEOUT_EN adds the idle-beat timeout; without it
//   TIMEOUT_ERR is tied low and no idle counter is built.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on REQ
//   GRANT | GNT held on owner; count beats until quantum or REQ drop
//   GAP   | one cycle with GNT=0 after a release; arbitrate as IDLE
module burst_rr_arbiter
   import arb_pkg::*;
#(
   parameter  int unsigned N       = ARB_N_DEF,
   parameter  int unsigned CNT_W   = ARB_CNT_W_DEF,
   parameter  int unsigned TIMEOUT = ARB_TIMEOUT_DEF,
   localparam int unsigned ID_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         REQ,
   input  logic                 BEAT,
   input  logic [N*CNT_W-1:0]   WEIGHT,
   output logic [N-1:0]         GNT,
   output logic [ID_W-1:0]      GNT_ID,
   output logic                 BUSY,
   output logic                 TIMEOUT_ERR
);

   arb_state_e        state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              busy_q, busy_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  quant_q, quant_d;

   logic [N-1:0]      pick_win;
   logic              pick_valid;
   logic [ID_W-1:0]   pick_id;
   logic [CNT_W-1:0]  pick_w;
   logic              to_hit;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]   idle_q, idle_d;
   logic              terr_q, terr_d;
`endif

   rr_pick #(.N(N)) u_pick (
      .req   (REQ),
      .ptr   (ptr_q),
      .win   (pick_win),
      .valid (pick_valid)
   );

   always_comb begin
      pick_id = '0;
      pick_w  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (pick_win[i]) begin
            pick_id = ID_W'(i);
            pick_w  = WEIGHT[i*CNT_W +: CNT_W];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign to_hit = !BEAT && ((idle_q + 1'b1) == TO_W'(TIMEOUT));
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      quant_d  = quant_q;
`ifdef ARB_TIMEOUT_EN
      idle_d   = idle_q;
      terr_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE, GAP: begin
            if (pick_valid) begin
               state_d  = GRANT;
               gnt_d    = pick_win;
               gnt_id_d = pick_id;
               busy_d   = 1'b1;
               cnt_d    = '0;
               // a zero quantum would never match cnt+1, so it means one beat
               quant_d  = (pick_w == '0) ? CNT_W'(1) : pick_w;
`ifdef ARB_TIMEOUT_EN
               idle_d   = '0;
`endif
            end else begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
            end
         end
         GRANT: begin
            if (BEAT) begin
               cnt_d = cnt_q + 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            idle_d = BEAT ? '0 : idle_q + 1'b1;
`endif
            // the beat of a REQ-drop cycle is counted; release happens once
            if (!(|(REQ & gnt_q)) || (BEAT && ((cnt_q + 1'b1) == quant_q)) || to_hit) begin
               state_d  = GAP;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
               ptr_d    = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
               terr_d   = to_hit;
`endif
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         quant_q  <= '0;
`ifdef ARB_TIMEOUT_EN
         idle_q   <= '0;
         terr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         quant_q  <= quant_d;
`ifdef ARB_TIMEOUT_EN
         idle_q   <= idle_d;
         terr_q   <= terr_d;
`endif
      end
   end

   assign GNT    = gnt_q;
   assign GNT_ID = gnt_id_q;
   assign BUSY   = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign TIMEOUT_ERR = terr_q;
`else
   assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// tb_burst_rr_arbiter
//   Self-checking bench for burst_rr_arbiter: a vector table for the basic
//   grant patterns, short directed sequences for the multi-cycle corners,
//   and a randomized run against a behavioural model.
module tb_burst_rr_arbiter;

   localparam int N       = 4;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  REQ;
   logic        BEAT;
   logic [15:0] WEIGHT;
   logic [3:0]  GNT;
   logic [1:0]  GNT_ID;
   logic        BUSY;
   logic        TIMEOUT_ERR;

   always #5 clk = ~clk;

   burst_rr_arbiter #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .REQ         (REQ),
      .BEAT        (BEAT),
      .WEIGHT      (WEIGHT),
      .GNT         (GNT),
      .GNT_ID      (GNT_ID),
      .BUSY        (BUSY),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: owner index (-1 = none), beats used, quantum, idle run
   int m_owner, m_ptr, m_cnt, m_quant, m_idle;
   bit m_terr;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_quant = 1; m_idle = 0; m_terr = 0;
   endtask

   task automatic model_step(input logic [3:0] req, input logic beat, input logic [15:0] w);
      bit to_hit;
      bit rel;
      bit found;
      int c;
      to_hit = 0;
      found  = 0;
      m_terr = 0;
      if (m_owner >= 0) begin
         if (beat) begin
            m_cnt++;
            m_idle = 0;
         end else begin
            m_idle++;
         end
`ifdef ARB_TIMEOUT_EN
         to_hit = (m_idle >= TIMEOUT);
`endif
         rel = !req[m_owner] || (beat && m_cnt >= m_quant) || to_hit;
         if (rel) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_terr  = to_hit;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && req[c]) begin
               found   = 1;
               m_owner = c;
            end
         end
         if (found) begin
            m_cnt   = 0;
            m_idle  = 0;
            m_quant = int'((w >> (CNT_W * m_owner)) & 16'hF);
            if (m_quant == 0) m_quant = 1;
         end
      end
   endtask

   task automatic compare_model();
      logic [3:0] eg;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      check("model_gnt", GNT, eg);
      check("model_gnt_id", GNT_ID, (m_owner >= 0) ? m_owner : 0);
      check("model_busy", BUSY, (m_owner >= 0));
      check("model_timeout_err", TIMEOUT_ERR, m_terr);
   endtask

   task automatic cycle(input logic [3:0] req, input logic beat, input logic [15:0] w);
      REQ = req; BEAT = beat; WEIGHT = w;
      @(posedge clk);
      model_step(req, beat, w);
      #1;
      compare_model();
   endtask

   // asserts reset away from the clock edge, checks the immediate clear
   task automatic reset_dut();
      rst_n = 1'b0;
      #2;
      model_reset();
      check("rst_gnt", GNT, 0);
      check("rst_gnt_id", GNT_ID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_timeout_err", TIMEOUT_ERR, 0);
      REQ = '0; BEAT = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          do_rst;
      logic [3:0]  req;
      logic        beat;
      logic [15:0] w;
      logic [3:0]  gnt;
      logic [1:0]  id;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; REQ = '0; BEAT = 1'b0; WEIGHT = '0;
      model_reset();

      // single requester 3 with quantum 1, then pointer wrap to requester 0
      tbl.push_back('{1'b1, 4'b1000, 1'b1, 16'h1111, 4'b1000, 2'd3});
      tbl.push_back('{1'b0, 4'b1000, 1'b1, 16'h1111, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b1001, 1'b0, 16'h1111, 4'b0001, 2'd0});
      tbl.push_back('{1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0});
      // all requesting, quantum 2, beat every cycle
      tbl.push_back('{1'b1, 4'b1111, 1'b1, 16'h2222, 4'b0001, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0001, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0010, 2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0010, 2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0100, 2'd2});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0100, 2'd2});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b1000, 2'd3});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b1000, 2'd3});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0000, 2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 16'h2222, 4'b0001, 2'd0});

      #3;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].do_rst) reset_dut();
         cycle(tbl[i].req, tbl[i].beat, tbl[i].w);
         check($sformatf("tbl%0d_gnt", i), GNT, tbl[i].gnt);
         check($sformatf("tbl%0d_id", i), GNT_ID, tbl[i].id);
         check($sformatf("tbl%0d_busy", i), BUSY, (tbl[i].gnt != 0));
         check($sformatf("tbl%0d_terr", i), TIMEOUT_ERR, 0);
      end

      // REQ[1] drops on the second beat of a quantum-4 grant
      reset_dut();
      cycle(4'b0010, 1'b1, 16'h1141);
      check("drop_first_gnt", GNT, 4'b0010);
      cycle(4'b0111, 1'b1, 16'h1141);
      check("drop_hold_gnt", GNT, 4'b0010);
      cycle(4'b0101, 1'b1, 16'h1141);
      check("drop_release_gnt", GNT, 4'b0000);
      cycle(4'b0101, 1'b0, 16'h1141);
      check("drop_next_gnt", GNT, 4'b0100);
      check("drop_next_id", GNT_ID, 2);

      // zero quantum behaves as one beat
      reset_dut();
      cycle(4'b0100, 1'b1, 16'h1011);
      check("q0_gnt", GNT, 4'b0100);
      cycle(4'b0100, 1'b1, 16'h1011);
      check("q0_release", GNT, 4'b0000);
      cycle(4'b0100, 1'b1, 16'h1011);
      check("q0_regrant", GNT, 4'b0100);

      // BEAT held low on a long quantum
      reset_dut();
      for (int k = 1; k <= 16; k++) begin
         cycle(4'b0001, 1'b0, 16'hFFFF);
         check($sformatf("to_hold%0d_gnt", k), GNT, 4'b0001);
         check($sformatf("to_hold%0d_terr", k), TIMEOUT_ERR, 0);
      end
`ifdef ARB_TIMEOUT_EN
      cycle(4'b0001, 1'b0, 16'hFFFF);
      check("to_revoke_gnt", GNT, 4'b0000);
      check("to_revoke_terr", TIMEOUT_ERR, 1);
      cycle(4'b0001, 1'b0, 16'hFFFF);
      check("to_after_gnt", GNT, 4'b0001);
      check("to_after_terr", TIMEOUT_ERR, 0);
`else
      for (int k = 17; k <= 40; k++) begin
         cycle(4'b0001, 1'b0, 16'hFFFF);
         check($sformatf("noto%0d_gnt", k), GNT, 4'b0001);
         check($sformatf("noto%0d_terr", k), TIMEOUT_ERR, 0);
      end
`endif

      // reset in the middle of a grant
      reset_dut();
      cycle(4'b0110, 1'b0, 16'h4444);
      check("mid_gnt", GNT, 4'b0010);
      cycle(4'b0110, 1'b0, 16'h4444);
      reset_dut();
      cycle(4'b0110, 1'b0, 16'h4444);
      check("mid_regrant_gnt", GNT, 4'b0010);
      check("mid_regrant_id", GNT_ID, 1);

      // randomized run against the model
      reset_dut();
      begin
         logic [3:0]  r_req;
         logic [15:0] r_w;
         logic        r_beat;
         r_req = 4'($urandom);
         r_w   = 16'($urandom);
         for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) r_w = 16'($urandom);
            r_beat = (n % 1000 < 500) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) reset_dut();
            cycle(r_req, r_beat, r_w);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
